// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each grant writes up to BURST_LEN words, stalls on full, and ends early when the owner drops req.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [ID_WIDTH-1:0]           owner,
  output logic                          busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [ID_WIDTH-1:0] owner_d;
  logic [ID_WIDTH-1:0] last_owner, last_owner_d;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_d;
  logic [ID_WIDTH-1:0] pick;
  logic                found;
  logic                accept;

  // Round-robin search starting just after the previous owner, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(last_owner) + i) % NUM_REQ]) begin
        pick  = ID_WIDTH'((int'(last_owner) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  // Zero-latency write qualifier: the word is written on the edge where ack is high.
  assign accept    = (state == GRANT) && req[owner] && !fifo_full;
  assign fifo_w_en = accept;
  assign busy      = (state == GRANT);

  always_comb begin
    ack      = '0;
    fifo_din = '0;
    if (accept) begin
      ack[owner] = 1'b1;
      fifo_din   = wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    beat_cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          // Early release: the owner ran out of data, no word is written this cycle.
          state_d      = IDLE;
          last_owner_d = owner;
          beat_cnt_d   = '0;
        end else if (!fifo_full) begin
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            state_d      = IDLE;
            last_owner_d = owner;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      beat_cnt   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// each cycle compared against a burst-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic            fifo_full;
  logic [N-1:0]    ack;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_din;
  logic [IW-1:0]   owner;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  // Model: whether a burst is active, who owns it, who owned the last one, words still allowed.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_left;

  // Layout: {w_en[15], ack[14:11], din[10:3], owner[2:1], busy[0]}
  logic [15:0] obs;
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (N),
    .BURST_LEN (BL),
    .ID_WIDTH  (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wdata    (wdata),
    .ack      (ack),
    .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en),
    .fifo_din (fifo_din),
    .owner    (owner),
    .busy     (busy)
  );

  function automatic logic [15:0] predict();
    logic          acc;
    logic [N-1:0]  a;
    logic [DW-1:0] d;
    acc = m_busy && req[m_owner] && !fifo_full;
    a   = acc ? (N'(1) << m_owner) : '0;
    d   = acc ? wdata[m_owner*DW +: DW] : '0;
    return {acc, a, d, IW'(m_owner), m_busy};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_left  = 0;
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_left = BL;
        m_busy = 1'b1;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (!fifo_full) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  // Sample at the falling edge, advance the model for the coming rising edge, drive after it.
  task automatic tick();
    @(negedge clk);
    exp_v = predict();
    obs   = {fifo_w_en, ack, fifo_din, owner, busy};
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    wdata     = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    fifo_full = 1'b0;
    wdata     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    compared++;
    if ({fifo_w_en, ack, fifo_din, owner, busy} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_async: got %h want %h", {fifo_w_en, ack, fifo_din, owner, busy}, 16'h0);
    end
    @(posedge clk);
    #1;
    compared++;
    if ({fifo_w_en, ack, fifo_din, owner, busy} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_held: got %h want %h", {fifo_w_en, ack, fifo_din, owner, busy}, 16'h0);
    end
  endtask

  task automatic test_single();
    int writes = 0;
    do_reset();
    req   = 4'b0001;
    wdata = {8'h00, 8'h00, 8'h00, 8'h11};
    for (int c = 0; c < 10; c++) begin
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL single cyc%0d: got %h want %h", c, obs, exp_v);
      end
      writes += int'(obs[15]);
    end
    compared++;
    if (writes != 8) begin
      mismatched++;
      $display("FAIL single_writes: got %0d want 8", writes);
    end
  endtask

  task automatic test_all_requesting();
    int   order[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    logic prev_wen = 1'b0;
    do_reset();
    req   = 4'b1111;
    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int c = 0; c < 25; c++) begin
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL all_req cyc%0d: got %h want %h", c, obs, exp_v);
      end
      compared++;
      if ($countones(obs[14:11]) != int'(obs[15])) begin
        mismatched++;
        $display("FAIL all_req_onehot cyc%0d: ack %b w_en %b", c, obs[14:11], obs[15]);
      end
      if (obs[15] && !prev_wen) order.push_back(int'(obs[2:1]));
      prev_wen = obs[15];
    end
    compared++;
    if (order.size() != 5) begin
      mismatched++;
      $display("FAIL all_req_bursts: got %0d want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (order[i] != exp_order[i]) begin
          mismatched++;
          $display("FAIL all_req_order%0d: got %0d want %0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    int stall_writes = 0;
    int stall_busy   = 0;
    int after_writes = 0;
    do_reset();
    req   = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL stall cyc%0d: got %h want %h", c, obs, exp_v);
      end
      if (c >= 3 && c <= 5) begin
        stall_writes += int'(obs[15]) + int'(obs[14:11] != 0);
        stall_busy   += int'(obs[0]);
      end
      if (c == 6 || c == 7) after_writes += int'(obs[15]);
      if (c == 8) begin
        compared++;
        if (obs[0] !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_release: busy got %b want 0", obs[0]);
        end
      end
    end
    compared++;
    if (stall_writes != 0 || stall_busy != 3) begin
      mismatched++;
      $display("FAIL stall_hold: writes %0d busy %0d want 0 and 3", stall_writes, stall_busy);
    end
    compared++;
    if (after_writes != 2) begin
      mismatched++;
      $display("FAIL stall_resume: got %0d want 2", after_writes);
    end
  endtask

  task automatic test_early_release();
    int writes3 = 0;
    do_reset();
    wdata = {8'hD3, 8'hD2, 8'h00, 8'h00};
    for (int c = 0; c < 8; c++) begin
      req = (c < 2) ? 4'b1100 : 4'b1000;
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL early cyc%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 2) begin
        compared++;
        if (obs[15] !== 1'b0) begin
          mismatched++;
          $display("FAIL early_drop: w_en got %b want 0", obs[15]);
        end
      end
      if (c == 4) begin
        compared++;
        if (obs[2:1] !== 2'd3) begin
          mismatched++;
          $display("FAIL early_next_owner: got %0d want 3", obs[2:1]);
        end
      end
      if (c >= 4) writes3 += int'(obs[15]);
    end
    compared++;
    if (writes3 != 4) begin
      mismatched++;
      $display("FAIL early_burst: got %0d want 4", writes3);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req   = 4'b1000;
    wdata = {8'hC3, 8'h00, 8'h00, 8'hC0};
    for (int c = 0; c < 2; c++) begin
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL midrst cyc%0d: got %h want %h", c, obs, exp_v);
      end
    end
    #1;
    compared++;
    if (fifo_w_en !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_second_write: w_en got %b want 1", fifo_w_en);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({fifo_w_en, ack, busy} !== 6'b0) begin
      mismatched++;
      $display("FAIL midrst_async: got %b want 000000", {fifo_w_en, ack, busy});
    end
    model_reset();
    #1;
    req   = 4'b1001;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL midrst_after cyc%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 1) begin
        compared++;
        if (obs[15] !== 1'b1 || obs[2:1] !== 2'd0) begin
          mismatched++;
          $display("FAIL midrst_first_owner: w_en %b owner %0d want 1 and 0", obs[15], obs[2:1]);
        end
      end
    end
  endtask

  task automatic test_full_at_grant();
    int early_writes = 0;
    int late_writes  = 0;
    do_reset();
    req   = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h77, 8'h00};
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c < 4);
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL full_grant cyc%0d: got %h want %h", c, obs, exp_v);
      end
      if (c >= 1 && c <= 3) begin
        early_writes += int'(obs[15]);
        compared++;
        if (obs[0] !== 1'b1) begin
          mismatched++;
          $display("FAIL full_grant_busy cyc%0d: got %b want 1", c, obs[0]);
        end
      end
      if (c >= 4 && c <= 7) late_writes += int'(obs[15]);
    end
    compared++;
    if (early_writes != 0 || late_writes != 4) begin
      mismatched++;
      $display("FAIL full_grant_writes: got %0d/%0d want 0/4", early_writes, late_writes);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req       = N'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      wdata     = $urandom;
      tick();
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL random cyc%0d: req %b full %b got %h want %h", c, req, fifo_full, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_full_at_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
